// File: rtl/panel_responder.sv
// Front-panel model for the lamp/switch scan matrix: settles and captures LED rows
// into a lamp image, and answers switch-row scans by pulling column lines low.
module panel_responder #(
    parameter int unsigned SETTLE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  led_row,
    input  logic [2:0]  sw_row,
    inout  wire  [11:0] col,
    input  logic [35:0] sw_image,
    output logic [95:0] lamp_image,
    output logic        frame_done,
    output logic        scan_err,
    input  logic        err_clear
);

    typedef enum logic [1:0] {
        IDLE,
        LED_SETTLE,
        LED_HOLD,
        SW_DRIVE
    } state_t;

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic [2:0]  r_row;
    logic [2:0]  w_row_next;
    logic [7:0]  r_mask;
    logic        r_frame_done;
    logic        r_scan_err;
    logic [11:0] r_lamp [0:7];

    logic [2:0]  w_led_idx;
    logic [2:0]  w_sw_idx;
    logic        w_is_led;
    logic        w_is_sw;
    logic        w_is_idle;
    logic        w_illegal;
    logic        w_same;
    logic        w_capture;
    logic [7:0]  w_cap_bit;
    logic [11:0] w_sw_sel;
    logic        w_drive_en;

    // Pattern classification on the live scanner outputs
    always_comb begin
        w_led_idx = 3'd0;
        w_sw_idx  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (led_row[i]) w_led_idx = 3'(i);
        end
        for (int i = 0; i < 3; i++) begin
            if (!sw_row[i]) w_sw_idx = 3'(i);
        end
    end

    assign w_is_led  = $onehot(led_row) && (sw_row == 3'b111);
    assign w_is_sw   = (led_row == 8'd0) && $onehot(~sw_row);
    assign w_is_idle = (led_row == 8'd0) && (sw_row == 3'b111);
    assign w_illegal = !(w_is_led || w_is_sw || w_is_idle);

    assign w_same = ((r_state == LED_SETTLE || r_state == LED_HOLD) && w_is_led && (w_led_idx == r_row))
                 || ((r_state == SW_DRIVE) && w_is_sw && (w_sw_idx == r_row));

    // Any change of pattern is re-evaluated exactly as it would be from IDLE
    always_comb begin
        w_state_next = IDLE;
        w_cnt_next   = 4'd0;
        w_row_next   = r_row;
        w_capture    = 1'b0;
        if (w_same) begin
            case (r_state)
                LED_SETTLE: begin
                    w_cnt_next = r_cnt + 4'd1;
                    if (r_cnt + 4'd1 == SETTLE_CNT) begin
                        w_capture    = 1'b1;
                        w_state_next = LED_HOLD;
                    end else begin
                        w_state_next = LED_SETTLE;
                    end
                end
                LED_HOLD: begin
                    w_cnt_next   = r_cnt;
                    w_state_next = LED_HOLD;
                end
                default: w_state_next = SW_DRIVE;
            endcase
        end else if (w_is_led) begin
            w_row_next = w_led_idx;
            w_cnt_next = 4'd1;
            if (SETTLE_CNT == 4'd1) begin
                w_capture    = 1'b1;
                w_state_next = LED_HOLD;
            end else begin
                w_state_next = LED_SETTLE;
            end
        end else if (w_is_sw) begin
            w_row_next   = w_sw_idx;
            w_state_next = SW_DRIVE;
        end
    end

    assign w_cap_bit = w_capture ? (8'd1 << w_row_next) : 8'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_row        <= 3'd0;
            r_mask       <= 8'd0;
            r_frame_done <= 1'b0;
            r_scan_err   <= 1'b0;
            for (int r = 0; r < 8; r++) r_lamp[r] <= 12'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_row   <= w_row_next;
            for (int r = 0; r < 8; r++) begin
                if (w_capture && (w_row_next == 3'(r))) r_lamp[r] <= ~col;
            end
            // Full mask is reported one cycle later and restarts the next frame
            if (r_mask == 8'hFF) begin
                r_frame_done <= 1'b1;
                r_mask       <= w_cap_bit;
            end else begin
                r_frame_done <= 1'b0;
                r_mask       <= r_mask | w_cap_bit;
            end
            if (w_illegal)      r_scan_err <= 1'b1;
            else if (err_clear) r_scan_err <= 1'b0;
        end
    end

    always_comb begin
        case (r_row[1:0])
            2'd0:    w_sw_sel = sw_image[11:0];
            2'd1:    w_sw_sel = sw_image[23:12];
            2'd2:    w_sw_sel = sw_image[35:24];
            default: w_sw_sel = 12'd0;
        endcase
    end

    // Live sw_row qualification releases the bus the same cycle the scanner moves on
    assign w_drive_en = (r_state == SW_DRIVE) && (sw_row == ~(3'b001 << r_row[1:0]));

    generate
        for (genvar gi = 0; gi < 12; gi++) begin : g_col
            assign col[gi] = (w_drive_en && w_sw_sel[gi]) ? 1'b0 : 1'bz;
        end
        for (genvar gi = 0; gi < 8; gi++) begin : g_lamp
            assign lamp_image[gi*12 +: 12] = r_lamp[gi];
        end
    endgenerate

    assign frame_done = r_frame_done;
    assign scan_err   = r_scan_err;

endmodule

// File: tb/tb_panel_responder.sv
// Directed bench for panel_responder: lamp capture timing, frame pulse, switch drive,
// illegal-scan flag and reset behaviour, with hand-computed expectations.
module tb_panel_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  led_row;
    logic [2:0]  sw_row;
    wire  [11:0] col;
    logic [35:0] sw_image;
    logic [95:0] lamp_image;
    logic        frame_done;
    logic        scan_err;
    logic        err_clear;

    logic        tb_drv;
    logic [11:0] tb_col;
    logic [95:0] exp_lamp;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign col = tb_drv ? tb_col : 12'bz;

    generate
        for (genvar gi = 0; gi < 12; gi++) begin : g_pu
            pullup (col[gi]);
        end
    endgenerate

    panel_responder #(.SETTLE(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .led_row    (led_row),
        .sw_row     (sw_row),
        .col        (col),
        .sw_image   (sw_image),
        .lamp_image (lamp_image),
        .frame_done (frame_done),
        .scan_err   (scan_err),
        .err_clear  (err_clear)
    );

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold one LED row for n cycles; lamp row must still be prev after 3 edges, data after 4
    task automatic scan_row(input int r, input logic [11:0] data, input logic [11:0] prev,
                            input int n, input int done_at);
        led_row = 8'(1 << r);
        sw_row  = 3'b111;
        tb_col  = ~data;
        tb_drv  = 1'b1;
        for (int k = 1; k <= n; k++) begin
            step(1);
            chk($sformatf("frame_done row%0d cyc%0d", r, k), 96'(frame_done), 96'(k == done_at));
            if (k == 3) chk($sformatf("lamp_pre row%0d", r), 96'(lamp_image[12*r +: 12]), 96'(prev));
            if (k == 4) chk($sformatf("lamp row%0d", r), 96'(lamp_image[12*r +: 12]), 96'(data));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; led_row = 8'd0; sw_row = 3'b111; sw_image = 36'd0;
        err_clear = 1'b0; tb_drv = 1'b0; tb_col = 12'd0;
        step(2);
        rst = 1'b0;
        chk("reset lamp", lamp_image, 96'd0);
        chk("reset frame_done", 96'(frame_done), 96'd0);
        chk("reset scan_err", 96'(scan_err), 96'd0);
        chk("reset col", 96'(col), 96'hFFF);

        // Reset while driving the bus releases it immediately
        sw_image = '1;
        sw_row   = 3'b110;
        #1 chk("sw0 pre-drive col", 96'(col), 96'hFFF);
        step(1);
        chk("sw0 drive col", 96'(col), 96'h000);
        rst = 1'b1;
        #1;
        chk("rst col release", 96'(col), 96'hFFF);
        chk("rst lamp", lamp_image, 96'd0);
        chk("rst scan_err", 96'(scan_err), 96'd0);
        chk("rst frame_done", 96'(frame_done), 96'd0);
        step(1);
        rst = 1'b0; sw_row = 3'b111; sw_image = 36'd0;
        step(1);

        // Frame 1: rows 0..7, pulse one cycle after row 7 capture
        for (int r = 0; r < 8; r++) scan_row(r, 12'(12'h100 + r), 12'h000, 6, (r == 7) ? 5 : 0);
        led_row = 8'd0; tb_drv = 1'b0;
        step(1);
        for (int r = 0; r < 8; r++) exp_lamp[12*r +: 12] = 12'(12'h100 + r);
        chk("frame1 lamp", lamp_image, exp_lamp);
        chk("frame1 scan_err", 96'(scan_err), 96'd0);
        chk("frame1 done low", 96'(frame_done), 96'd0);

        // Short row: three cycles only
        led_row = 8'h04; tb_col = ~12'hBEE; tb_drv = 1'b1;
        step(3);
        led_row = 8'd0; tb_drv = 1'b0;
        step(2);
        chk("short row2", 96'(lamp_image[35:24]), 96'h102);

        // Switch read of row 1
        sw_image = {12'h000, 12'hA5C, 12'h000};
        sw_row   = 3'b101;
        #1 chk("sw1 pre-drive col", 96'(col), 96'hFFF);
        for (int k = 1; k <= 4; k++) begin
            step(1);
            chk($sformatf("sw1 col cyc%0d", k), 96'(col), 96'h5A3);
        end
        sw_row = 3'b111;
        #1 chk("sw1 release col", 96'(col), 96'hFFF);
        step(1);
        sw_image = 36'd0;

        // Illegal patterns
        led_row = 8'h03; tb_col = ~12'h777; tb_drv = 1'b1;
        step(1);
        chk("illegal set", 96'(scan_err), 96'd1);
        step(4);
        chk("illegal no capture", lamp_image, exp_lamp);
        err_clear = 1'b1;
        step(1);
        chk("set wins over clear", 96'(scan_err), 96'd1);
        led_row = 8'd0; tb_drv = 1'b0;
        step(1);
        chk("err_clear", 96'(scan_err), 96'd0);
        err_clear = 1'b0;
        led_row = 8'h01; sw_row = 3'b110;
        step(1);
        chk("led+sw illegal", 96'(scan_err), 96'd1);
        led_row = 8'd0; sw_row = 3'b111; err_clear = 1'b1;
        step(1);
        err_clear = 1'b0;
        chk("err_clear 2", 96'(scan_err), 96'd0);

        // Frame 2: row 2 last, row 5 captured twice
        scan_row(0, 12'h200, 12'h100, 6, 0);
        scan_row(1, 12'h201, 12'h101, 6, 0);
        scan_row(3, 12'h203, 12'h103, 6, 0);
        scan_row(4, 12'h204, 12'h104, 6, 0);
        scan_row(5, 12'hAAA, 12'h105, 6, 0);
        led_row = 8'd0; tb_drv = 1'b0;
        step(1);
        chk("rescan gap done", 96'(frame_done), 96'd0);
        scan_row(5, 12'h555, 12'hAAA, 6, 0);
        scan_row(6, 12'h206, 12'h106, 6, 0);
        scan_row(7, 12'h207, 12'h107, 6, 0);
        scan_row(2, 12'h202, 12'h102, 6, 5);
        led_row = 8'd0; tb_drv = 1'b0;
        step(1);
        chk("rescan row5 latest", 96'(lamp_image[71:60]), 96'h555);

        // Reset mid-frame discards the partial mask
        for (int r = 0; r < 4; r++) scan_row(r, 12'(12'h300 + r), 12'(12'h200 + r), 6, 0);
        led_row = 8'd0; tb_drv = 1'b0;
        rst = 1'b1;
        #1 chk("midframe rst lamp", lamp_image, 96'd0);
        step(1);
        rst = 1'b0;
        step(1);
        for (int r = 4; r < 8; r++) scan_row(r, 12'(12'h400 + r), 12'h000, 6, 0);
        led_row = 8'd0; tb_drv = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(1);
            chk($sformatf("post-rst no done %0d", k), 96'(frame_done), 96'd0);
        end
        for (int r = 0; r < 4; r++) scan_row(r, 12'(12'h500 + r), 12'h000, 6, (r == 3) ? 5 : 0);
        led_row = 8'd0; tb_drv = 1'b0;
        step(1);
        chk("final scan_err", 96'(scan_err), 96'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/panel_responder.md
# panel_responder

Behavioural and synthesizable model of the physical front panel on the pynq_z2 lamp/switch matrix: the far end of the row/column scan driven by the panel scanner. It watches `led_row`/`sw_row`, captures lamp states from the shared `col` bus into a lamp image, and answers switch-row scans by pulling `col` bits low for closed switches. It is used in simulation benches and in loopback builds in place of the real panel board.

## Interface
- `SETTLE`, 4: consecutive cycles an LED row pattern must be stable before its columns are captured (range 1..15).
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `led_row`  in  8  lamp row selects from scanner, active-high, one-hot when valid.
- `sw_row`  in  3  switch row selects from scanner, active-low, one-hot-low when valid.
- `col`  inout  12  shared column bus; scanner drives it in LED phase (low = lamp lit); this block drives it open-drain in switch phase.
- `sw_image`  in  36  switch closures, bits [12k+11:12k] = row k, 1 = closed.
- `lamp_image`  out  96  captured lamps, bits [12r+11:12r] = row r, 1 = lit.
- `frame_done`  out  1  one-cycle pulse when all 8 lamp rows captured since last pulse.
- `scan_err`  out  1  sticky illegal-scan flag.
- `err_clear`  in  1  synchronous clear of `scan_err`.

## Operation
- Pattern classification (combinational on inputs):
  - LED-row r: `led_row` exactly bit r set, `sw_row` = 3'b111.
  - SW-row k: `sw_row` exactly bit k low, `led_row` = 0.
  - Idle: `led_row` = 0, `sw_row` = 3'b111.
  - Illegal: anything else (multiple LED bits, multiple SW bits low, LED and SW simultaneously).
- FSM states: IDLE, LED_SETTLE, LED_HOLD, SW_DRIVE.
  - IDLE: LED-row r -> LED_SETTLE (cnt=1, row=r); SW-row k -> SW_DRIVE (row=k).
  - LED_SETTLE: same pattern -> cnt+1; when cnt reaches SETTLE, capture `lamp_image[row] <= ~col`, set mask bit row, -> LED_HOLD. Pattern change -> re-evaluate as from IDLE in the same cycle.
  - LED_HOLD: same pattern stays; no further capture. Pattern change -> re-evaluate as from IDLE.
  - SW_DRIVE: `col_oe` asserted; stays while same SW-row k; change -> re-evaluate as from IDLE.
  - Illegal pattern in any state -> IDLE, `scan_err` set, no capture, no drive.
- Column drive: `col[i]` = 0 when state is SW_DRIVE AND current `sw_row` still selects the registered row AND `sw_image[12k+i]` = 1; otherwise high-Z. Qualification by live `sw_row` makes release combinational (no overlap with next LED phase).
- Frame: 8-bit capture mask; when it becomes 8'hFF, `frame_done` pulses next cycle and mask clears. Re-capturing an already-set row overwrites its lamp data, mask unchanged.
- `scan_err`: set on illegal pattern; `err_clear` clears; simultaneous set and clear -> set wins.

## Timing
- Reset (async): state IDLE, cnt 0, mask 0, `lamp_image` 0, `frame_done` 0, `scan_err` 0, `col` high-Z immediately.
- Lamp capture latency: row asserted at edge 0 -> `lamp_image` updated at edge SETTLE (capture uses `col` sampled at that edge).
- Switch response: SW-row asserted at edge 0 -> `col` driven after edge 1; released combinationally the cycle `sw_row` changes.
- Row held shorter than SETTLE cycles: no capture, no mask change.
- `frame_done`: exactly one cycle, the cycle after the eighth distinct row capture.
- Reset mid-capture: partial mask discarded; next frame starts from empty mask.

## Test plan
- Reset: assert `rst` mid SW_DRIVE with `sw_image` all 1s -> `col` high-Z same cycle, all outputs 0.
- Lamp scan, SETTLE=4: scan rows 0..7 for 6 cycles each, `col` = ~(12'h100+r) -> `lamp_image` row r = 12'h100+r, `frame_done` single pulse one cycle after row 7 capture, `scan_err` 0.
- Short row: `led_row`=8'h04 for 3 cycles then idle -> row 2 unchanged, mask unchanged.
- Switch read: `sw_image` row 1 = 12'hA5C, `sw_row`=3'b101 for 4 cycles -> `col` = 12'hA5C inverted-low pattern (bits set in A5C read 0, others Z/pull-up 1) from cycle 2; Z the cycle `sw_row` returns to 3'b111.
- Illegal: `led_row`=8'h03 -> `scan_err`=1, no capture; `err_clear` with simultaneous illegal pattern -> stays 1; `err_clear` alone -> 0.
- Rescan: capture row 5 twice with different data within one frame -> latest data kept, `frame_done` only after remaining rows captured.
